jk_cmd_driver: RTL and testbench

- Upstream drive stage for the JK flip-flop cell. Accepts buffered flip-flop commands (hold/reset/set/toggle, each with a repeat length) over a valid/ready interface.
- Replays each command as registered J/K levels for exactly the requested number of cycles, then returns the lines to hold (00).
- Keeps a cycle-accurate model of the downstream Q so the integration bench and system logic can check the flip-flop.

---
 rtl/jk_cmd_driver.sv | 165 ++++++++++++++++
 tb/tb_jk_cmd_driver.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/jk_cmd_driver.sv
// Command FIFO plus replay FSM that drives registered J/K levels into a JK flip-flop
// for a programmed number of cycles, and mirrors the flip-flop's Q in q_model.
module jk_cmd_driver #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [LEN_W-1:0]         cmd_len,
  output logic                     J,
  output logic                     K,
  output logic                     busy,
  output logic                     done,
  output logic                     q_model,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [1:0]       op;
    logic [LEN_W-1:0] len;
  } cmd_t;

  typedef enum logic {S_IDLE, S_DRIVE} state_t;

  state_t           state_q, state_d;
  cmd_t             mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             j_q, j_d, k_q, k_d;
  logic             done_q, done_d;
  logic             q_q, q_d;

  logic push, pop, empty, full, head_null, last;
  cmd_t head, cmd_in;

  // Ready comes from registered occupancy only, so a pop never raises it in the same cycle.
  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign cmd_in    = '{op: cmd_op, len: cmd_len};
  assign head      = mem_q[rd_ptr_q];
  assign head_null = (head.len == '0);
  assign last      = (cnt_q == LEN_W'(1));

  // FIFO storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      done_q   <= 1'b0;
      q_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      j_q      <= j_d;
      k_q      <= k_d;
      done_q   <= done_d;
      q_q      <= q_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty && !head_null) state_d = S_DRIVE;
      S_DRIVE: if (last && (empty || head_null)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // done is registered so it is high during the final driven cycle of a command,
  // or during the cycle after a null command is popped.
  always_comb begin
    pop    = 1'b0;
    j_d    = j_q;
    k_d    = k_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        j_d = 1'b0;
        k_d = 1'b0;
        if (!empty) begin
          pop = 1'b1;
          if (!head_null) begin
            {j_d, k_d} = head.op;
            cnt_d      = head.len;
            done_d     = (head.len == LEN_W'(1));
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_DRIVE: begin
        cnt_d = cnt_q - LEN_W'(1);
        if (last) begin
          j_d = 1'b0;
          k_d = 1'b0;
          if (!empty) begin
            pop = 1'b1;
            if (!head_null) begin
              {j_d, k_d} = head.op;
              cnt_d      = head.len;
              done_d     = (head.len == LEN_W'(1));
            end else begin
              done_d = 1'b1;
            end
          end
        end else begin
          done_d = (cnt_q == LEN_W'(2));
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Same edge the downstream flip-flop samples J/K, so q_model tracks Q exactly.
  always_comb begin
    case ({j_q, k_q})
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  assign J          = j_q;
  assign K          = k_q;
  assign busy       = (state_q == S_DRIVE);
  assign done       = done_q;
  assign q_model    = q_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Directed-vector bench for jk_cmd_driver; expected values are hand-derived per cycle.
module tb_jk_cmd_driver;

  localparam int DEPTH = 4;
  localparam int LEN_W = 4;

  logic             clk, rst;
  logic             cmd_valid, cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             J, K, busy, done, q_model;
  logic [2:0]       fifo_level;

  int n_vec, n_miss;

  jk_cmd_driver #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len),
    .J(J), .K(K), .busy(busy), .done(done), .q_model(q_model),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [LEN_W-1:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    step();
    cmd_valid = 1'b0;
  endtask

  // bundle = {J,K,q_model,done,busy}
  logic [4:0] exp_st [10];
  logic [4:0] exp_bb [5];

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int ndone, guard, bad;
    n_vec = 0; n_miss = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0;

    // reset state
    repeat (3) step();
    chk("rst_bundle", {J, K, q_model, done, busy}, 5'b00000);
    chk("rst_level",  fifo_level, 0);
    chk("rst_ready",  cmd_ready, 1);
    rst = 1'b0;
    repeat (2) step();
    chk("post_rst_bundle", {J, K, q_model, done, busy}, 5'b00000);
    chk("post_rst_level",  {cmd_ready, fifo_level}, 4'b1000);

    // set len3 then toggle len5, back to back
    exp_st = '{5'b10001, 5'b10101, 5'b10111, 5'b11101, 5'b11001,
               5'b11101, 5'b11001, 5'b11111, 5'b00000, 5'b00000};
    push(2'b10, 4'd3);
    push(2'b11, 4'd5);
    for (int i = 0; i < 10; i++) begin
      if (i != 0) step();
      chk($sformatf("set_tog_c%0d", i), {J, K, q_model, done, busy}, exp_st[i]);
    end

    // set len2 then reset len2, no gap
    exp_bb = '{5'b10001, 5'b10111, 5'b01101, 5'b01011, 5'b00000};
    push(2'b10, 4'd2);
    push(2'b01, 4'd2);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) step();
      chk($sformatf("b2b_c%0d", i), {J, K, q_model, done, busy}, exp_bb[i]);
    end

    // back-pressure: set len6 while five timed holds are offered
    push(2'b10, 4'd6);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_len = 4'd1;
    ndone = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      ndone += int'(done);
      if (c == 4) chk("bp_full_c4",  {cmd_ready, fifo_level}, 4'b0100);
      if (c == 6) chk("bp_held_c6",  {cmd_ready, fifo_level, J, busy}, 6'b010011);
      if (c == 7) chk("bp_ready_c7", {cmd_ready, fifo_level}, 4'b1011);
      if (c == 8) chk("bp_accept_c8", {cmd_ready, fifo_level}, 4'b1011);
    end
    cmd_valid = 1'b0;
    guard = 0;
    while ((busy || fifo_level != 0) && guard < 40) begin
      step();
      ndone += int'(done);
      guard++;
    end
    chk("bp_drain_bound", guard < 40, 1);
    chk("bp_done_count", ndone, 6);
    chk("bp_q_final", {J, K, q_model}, 3'b001);

    // null command while idle
    push(2'b11, 4'd0);
    chk("null_c0", {J, K, q_model, done, busy}, 5'b00100);
    chk("null_lvl", fifo_level, 1);
    step();
    chk("null_c1", {J, K, q_model, done, busy}, 5'b00110);
    step();
    chk("null_c2", {J, K, q_model, done, busy, fifo_level}, 8'b00100000);

    // async reset in the middle of a long toggle with two commands queued
    push(2'b11, 4'd8);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 4'd3;
    step();
    cmd_op = 2'b01;
    step();
    cmd_valid = 1'b0;
    step();
    chk("ar_pre", {J, K, busy, fifo_level}, 6'b111010);
    #2 rst = 1'b1;
    #1;
    chk("ar_now", {J, K, q_model, done, busy, fifo_level}, 8'b00000000);
    chk("ar_ready", cmd_ready, 1);
    #1 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (J || K || done || busy || fifo_level != 0 || q_model) bad++;
    end
    chk("ar_quiet", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
